// File: rtl/sign_monitor_pkg.sv
// sign_monitor_pkg
// Shared types and encodings for the sign run-length monitor.
//   state_t        : FSM states (S_ERR only exists when SIGN_MONITOR_ERR_CHECK_EN
//                    is defined)
//   sample_class_t : classification of one valid sample (Z, P, N, B)
//   RUN_SIGN_*     : encodings driven on run_sign
//   classify / class_to_state / state_to_sign : small pure helpers
package sign_monitor_pkg;

    typedef enum logic [1:0] {
        S_ZERO = 2'b00,
        S_POS  = 2'b01,
        S_NEG  = 2'b10
`ifdef SIGN_MONITOR_ERR_CHECK_EN
        ,
        S_ERR  = 2'b11
`endif
    } state_t;

    typedef enum logic [1:0] {
        CLS_Z = 2'b00,
        CLS_P = 2'b01,
        CLS_N = 2'b10,
        CLS_B = 2'b11
    } sample_class_t;

    localparam logic [1:0] RUN_SIGN_ZERO = 2'b00;
    localparam logic [1:0] RUN_SIGN_POS  = 2'b01;
    localparam logic [1:0] RUN_SIGN_NEG  = 2'b10;

    function automatic sample_class_t classify(input logic pos, input logic neg);
        sample_class_t cls;
        case ({neg, pos})
            2'b01:   cls = CLS_P;
            2'b10:   cls = CLS_N;
            2'b11:   cls = CLS_B;
            default: cls = CLS_Z;
        endcase
        return cls;
    endfunction

    // B maps to S_ZERO here; when error checking is enabled the caller
    // intercepts B before this mapping is used.
    function automatic state_t class_to_state(input sample_class_t cls);
        state_t st;
        case (cls)
            CLS_P:   st = S_POS;
            CLS_N:   st = S_NEG;
            default: st = S_ZERO;
        endcase
        return st;
    endfunction

    function automatic logic [1:0] state_to_sign(input state_t st);
        logic [1:0] sgn;
        case (st)
            S_POS:   sgn = RUN_SIGN_POS;
            S_NEG:   sgn = RUN_SIGN_NEG;
            default: sgn = RUN_SIGN_ZERO;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/sign_monitor_run_counter.sv
// run_counter
// Saturating run-length counter.
//   clk, rst : clock and synchronous active-high reset (count -> 0)
//   zero     : force count to 0 (highest priority)
//   load1    : start a new run, count -> 1
//   inc      : extend the run, count + 1 saturating at 2^RUN_W-1
//   count    : current run length
module run_counter #(
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load1,
    input  logic             zero,
    output logic [RUN_W-1:0] count
);

    localparam logic [RUN_W-1:0] COUNT_MAX = '1;
    localparam logic [RUN_W-1:0] COUNT_ONE = RUN_W'(1);

    logic [RUN_W-1:0] count_reg;
    logic [RUN_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (zero) begin
            count_next = '0;
        end else if (load1) begin
            count_next = COUNT_ONE;
        end else if (inc && (count_reg != COUNT_MAX)) begin
            count_next = count_reg + COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/sign_monitor.sv
// sign_monitor
// Tracks runs of positive / negative / zero samples from an upstream sign
// classifier and hands completed runs to a consumer over a valid/ready
// report port. A new report arriving while the previous one is still
// unaccepted is dropped and flagged as overrun.
// Optional feature: define SIGN_MONITOR_ERR_CHECK_EN to trap samples with
// both flags high in S_ERR (sets error) until clear.
//   clk, rst                     : clock, synchronous active-high reset
//   positive_flag, negative_flag : sample sign flags
//   valid_in                     : flags carry a new sample
//   clear                        : clears error/overrun (and leaves S_ERR)
//   run_ready                    : consumer accepts the pending report
//   run_valid, run_len, run_sign : pending run report
//   change_pulse                 : one-cycle pulse on direct POS<->NEG change
//   overrun                      : sticky, a completed run was dropped
//   error                        : sticky, both flags seen high together
module sign_monitor
    import sign_monitor_pkg::*;
#(
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             positive_flag,
    input  logic             negative_flag,
    input  logic             valid_in,
    input  logic             clear,
    input  logic             run_ready,
    output logic             run_valid,
    output logic [RUN_W-1:0] run_len,
    output logic [1:0]       run_sign,
    output logic             change_pulse,
    output logic             overrun,
    output logic             error
);

    state_t           state_reg, state_next;
    logic             run_valid_reg, run_valid_next;
    logic [RUN_W-1:0] run_len_reg, run_len_next;
    logic [1:0]       run_sign_reg, run_sign_next;
    logic             change_pulse_reg, change_pulse_next;
    logic             overrun_reg, overrun_next;
`ifdef SIGN_MONITOR_ERR_CHECK_EN
    logic             error_reg, error_next;
`endif

    logic             cnt_inc, cnt_load1, cnt_zero;
    logic [RUN_W-1:0] count;
    sample_class_t    sample_cls;
    state_t           sample_state;

    assign sample_cls   = classify(positive_flag, negative_flag);
    assign sample_state = class_to_state(sample_cls);

    run_counter #(
        .RUN_W (RUN_W)
    ) u_run_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .zero  (cnt_zero),
        .count (count)
    );

    always_comb begin
        state_next        = state_reg;
        run_valid_next    = run_valid_reg;
        run_len_next      = run_len_reg;
        run_sign_next     = run_sign_reg;
        change_pulse_next = 1'b0;
        overrun_next      = overrun_reg;
`ifdef SIGN_MONITOR_ERR_CHECK_EN
        error_next        = error_reg;
`endif
        cnt_inc           = 1'b0;
        cnt_load1         = 1'b0;
        cnt_zero          = 1'b0;

        // Handshake runs independently of sample processing; a completion
        // below may reload the report in the same cycle.
        if (run_valid_reg && run_ready) begin
            run_valid_next = 1'b0;
        end

        if (clear) begin
            overrun_next = 1'b0;
`ifdef SIGN_MONITOR_ERR_CHECK_EN
            error_next   = 1'b0;
            if (state_reg == S_ERR) begin
                state_next = S_ZERO;
                cnt_zero   = 1'b1;
            end
`endif
        end else if (valid_in) begin
`ifdef SIGN_MONITOR_ERR_CHECK_EN
            if (state_reg == S_ERR) begin
                // Trapped: samples ignored until clear.
            end else if (sample_cls == CLS_B) begin
                state_next = S_ERR;
                error_next = 1'b1;
                cnt_zero   = 1'b1;
            end else begin
`else
            begin
`endif
                if (sample_state == state_reg) begin
                    cnt_inc = 1'b1;
                end else begin
                    state_next = sample_state;
                    cnt_load1  = 1'b1;
                    change_pulse_next =
                        ((state_reg == S_POS) && (sample_state == S_NEG)) ||
                        ((state_reg == S_NEG) && (sample_state == S_POS));
                    // An empty run (only possible right after reset/clear
                    // from S_ERR) produces no report.
                    if (count != '0) begin
                        if (run_valid_reg && !run_ready) begin
                            overrun_next = 1'b1;
                        end else begin
                            run_valid_next = 1'b1;
                            run_len_next   = count;
                            run_sign_next  = state_to_sign(state_reg);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_ZERO;
            run_valid_reg    <= 1'b0;
            run_len_reg      <= '0;
            run_sign_reg     <= RUN_SIGN_ZERO;
            change_pulse_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            run_valid_reg    <= run_valid_next;
            run_len_reg      <= run_len_next;
            run_sign_reg     <= run_sign_next;
            change_pulse_reg <= change_pulse_next;
            overrun_reg      <= overrun_next;
        end
    end

`ifdef SIGN_MONITOR_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            error_reg <= 1'b0;
        end else begin
            error_reg <= error_next;
        end
    end
    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

    assign run_valid    = run_valid_reg;
    assign run_len      = run_len_reg;
    assign run_sign     = run_sign_reg;
    assign change_pulse = change_pulse_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sign_monitor.sv
// tb_sign_monitor
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of run tracking kept in plain integers.
module tb_sign_monitor;

    localparam int RUN_W   = 8;
    localparam int CNT_MAX = (1 << RUN_W) - 1;
`ifdef SIGN_MONITOR_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             positive_flag = 1'b0;
    logic             negative_flag = 1'b0;
    logic             valid_in = 1'b0;
    logic             clear = 1'b0;
    logic             run_ready = 1'b0;
    logic             run_valid;
    logic [RUN_W-1:0] run_len;
    logic [1:0]       run_sign;
    logic             change_pulse;
    logic             overrun;
    logic             error;

    sign_monitor #(
        .RUN_W (RUN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .positive_flag (positive_flag),
        .negative_flag (negative_flag),
        .valid_in      (valid_in),
        .clear         (clear),
        .run_ready     (run_ready),
        .run_valid     (run_valid),
        .run_len       (run_len),
        .run_sign      (run_sign),
        .change_pulse  (change_pulse),
        .overrun       (overrun),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Model: current run class 0=zero 1=pos 2=neg 3=error-trap, and length.
    int m_cls = 0;
    int m_cnt = 0;
    int m_valid = 0, m_len = 0, m_sign = 0, m_pulse = 0, m_ovr = 0, m_err = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_step = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit v, input bit p, input bit n,
                                input bit c, input bit rd);
        int cls;
        int nvalid;
        if (r) begin
            m_cls = 0; m_cnt = 0; m_valid = 0; m_len = 0; m_sign = 0;
            m_pulse = 0; m_ovr = 0; m_err = 0;
            return;
        end
        m_pulse = 0;
        nvalid = (m_valid != 0 && rd) ? 0 : m_valid;
        if (c) begin
            m_ovr = 0;
            m_err = 0;
            if (m_cls == 3) begin m_cls = 0; m_cnt = 0; end
        end else if (v && m_cls != 3) begin
            if (p && n) cls = ERR_EN ? 3 : 0;
            else if (p) cls = 1;
            else if (n) cls = 2;
            else cls = 0;
            if (cls == 3) begin
                m_cls = 3; m_err = 1; m_cnt = 0;
            end else if (cls == m_cls) begin
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end else begin
                if (m_cnt > 0) begin
                    if (m_valid != 0 && !rd) m_ovr = 1;
                    else begin nvalid = 1; m_len = m_cnt; m_sign = m_cls; end
                end
                m_pulse = ((m_cls == 1 && cls == 2) || (m_cls == 2 && cls == 1)) ? 1 : 0;
                m_cls = cls;
                m_cnt = 1;
            end
        end
        m_valid = nvalid;
    endtask

    // One clock cycle: drive inputs, advance model, sample #1 after the edge.
    task automatic step(input string tag, input bit r, input bit v, input bit p,
                        input bit n, input bit c, input bit rd);
        rst = r; valid_in = v; positive_flag = p; negative_flag = n;
        clear = c; run_ready = rd;
        model_update(r, v, p, n, c, rd);
        @(posedge clk);
        #1;
        n_step++;
        $display("[%0d] %s rst=%0b v=%0b p=%0b n=%0b clr=%0b rdy=%0b -> rv=%0b len=%0d sign=%0d pulse=%0b ovr=%0b err=%0b",
                 n_step, tag, r, v, p, n, c, rd, run_valid, run_len, run_sign,
                 change_pulse, overrun, error);
        chk({tag, ".run_valid"}, 32'(run_valid), 32'(m_valid));
        chk({tag, ".run_len"}, 32'(run_len), 32'(m_len));
        chk({tag, ".run_sign"}, 32'(run_sign), 32'(m_sign));
        chk({tag, ".change_pulse"}, 32'(change_pulse), 32'(m_pulse));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".error"}, 32'(error), 32'(m_err));
    endtask

    initial begin
        bit p, n, v, c, r, rd;

        // Reset state
        step("reset", 1, 0, 0, 0, 0, 0);
        chk("reset.all_zero", 32'({run_valid, run_len, run_sign, change_pulse, overrun, error}), 32'd0);

        // P,P,P,N with ready: report {01,3} for one cycle, pulse for one cycle
        step("ppp_n", 0, 1, 1, 0, 0, 1);
        step("ppp_n", 0, 1, 1, 0, 0, 1);
        step("ppp_n", 0, 1, 1, 0, 0, 1);
        step("ppp_n", 0, 1, 0, 1, 0, 1);
        chk("ppp_n.valid", 32'(run_valid), 32'd1);
        chk("ppp_n.len", 32'(run_len), 32'd3);
        chk("ppp_n.sign", 32'(run_sign), 32'd1);
        chk("ppp_n.pulse", 32'(change_pulse), 32'd1);
        step("ppp_n_after", 0, 0, 0, 0, 0, 1);
        chk("ppp_n.valid_drop", 32'(run_valid), 32'd0);
        chk("ppp_n.pulse_drop", 32'(change_pulse), 32'd0);

        // 300 P then Z: saturated length 255
        step("sat_rst", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step("sat_p", 0, 1, 1, 0, 0, 1);
        step("sat_z", 0, 1, 0, 0, 0, 1);
        chk("sat.len", 32'(run_len), 32'd255);
        chk("sat.sign", 32'(run_sign), 32'd1);
        chk("sat.pulse", 32'(change_pulse), 32'd0);

        // Overrun with ready low: P,P,N,Z keeps {01,2}
        step("ovr_rst", 1, 0, 0, 0, 0, 0);
        step("ovr", 0, 1, 1, 0, 0, 0);
        step("ovr", 0, 1, 1, 0, 0, 0);
        step("ovr", 0, 1, 0, 1, 0, 0);
        step("ovr", 0, 1, 0, 0, 0, 0);
        chk("ovr.valid", 32'(run_valid), 32'd1);
        chk("ovr.report", 32'({run_sign, run_len}), 32'({2'b01, 8'd2}));
        chk("ovr.flag", 32'(overrun), 32'd1);
        step("ovr_accept", 0, 0, 0, 0, 0, 1);
        chk("ovr.accepted", 32'(run_valid), 32'd0);
        step("ovr_clear", 0, 0, 0, 0, 1, 0);
        chk("ovr.cleared", 32'(overrun), 32'd0);

        // Reset in the middle of N,N: nothing reported
        step("rstmid", 0, 1, 0, 1, 0, 1);
        step("rstmid", 0, 1, 0, 1, 0, 1);
        step("rstmid_rst", 1, 1, 0, 1, 0, 1);
        chk("rstmid.all_zero", 32'({run_valid, run_len, run_sign, change_pulse, overrun, error}), 32'd0);
        step("rstmid_p", 0, 1, 1, 0, 0, 1);
        chk("rstmid.no_report", 32'(run_valid), 32'd0);

        // Gaps inside a run: P,gap,P,gap,Z -> len 2
        step("gap_rst", 1, 0, 0, 0, 0, 0);
        step("gap", 0, 1, 1, 0, 0, 1);
        step("gap", 0, 0, 0, 1, 0, 1);
        step("gap", 0, 1, 1, 0, 0, 1);
        step("gap", 0, 0, 1, 1, 0, 1);
        step("gap", 0, 1, 0, 0, 0, 1);
        chk("gap.len", 32'(run_len), 32'd2);
        chk("gap.valid", 32'(run_valid), 32'd1);

`ifdef SIGN_MONITOR_ERR_CHECK_EN
        // Error trap: P then B, further samples ignored, clear releases
        step("err_rst", 1, 0, 0, 0, 0, 0);
        step("err", 0, 1, 1, 0, 0, 1);
        step("err_b", 0, 1, 1, 1, 0, 1);
        chk("err.flag", 32'(error), 32'd1);
        chk("err.no_report", 32'(run_valid), 32'd0);
        step("err_ign", 0, 1, 0, 1, 0, 1);
        step("err_ign", 0, 1, 1, 0, 0, 1);
        chk("err.ignored", 32'(run_valid), 32'd0);
        step("err_clr", 0, 1, 1, 0, 1, 1);
        chk("err.cleared", 32'(error), 32'd0);
        step("err_p", 0, 1, 1, 0, 0, 1);
        step("err_z", 0, 1, 0, 0, 0, 1);
        chk("err.restart_len", 32'(run_len), 32'd1);
        chk("err.restart_sign", 32'(run_sign), 32'd1);
`else
        // B behaves as Z when error checking is disabled
        step("b_rst", 1, 0, 0, 0, 0, 0);
        step("b", 0, 1, 1, 0, 0, 1);
        step("b", 0, 1, 1, 1, 0, 1);
        chk("b.as_zero_len", 32'(run_len), 32'd1);
        chk("b.error_low", 32'(error), 32'd0);
`endif

        // Randomized traffic with sticky sign choices to form runs
        step("rnd_rst", 1, 0, 0, 0, 0, 0);
        p = 0; n = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                p = 1'($urandom_range(1));
                n = 1'($urandom_range(1));
            end
            v  = ($urandom_range(3) != 0);
            rd = 1'($urandom_range(1));
            c  = ($urandom_range(49) == 0);
            r  = ($urandom_range(199) == 0);
            step("rnd", r, v, p, n, c, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
